// File: rtl/perf_pkg.sv
// Shared constants and helpers for the performance counter bank.
package perf_pkg;

    localparam int PERF_MAX_CH      = 16;
    localparam int PERF_MODE_WRAP   = 0;
    localparam int PERF_MODE_SAT    = 1;
    localparam int PERF_DEFAULT_DIV = 1;

    // Address width that stays legal for a single-channel bank.
    function automatic int perf_addr_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/perf_counter_bank_if.sv
// Configuration, event, read and overflow signals of the performance counter bank.
interface perf_counter_bank_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 64,
    parameter int DIV_W  = 8
);
    import perf_pkg::*;

    localparam int AW = perf_addr_w(NUM_CH);

    logic              En;
    logic [NUM_CH-1:0] Event;
    logic [NUM_CH-1:0] Clr;
    logic              CfgWe;
    logic [AW-1:0]     CfgAddr;
    logic [DIV_W-1:0]  CfgDiv;
    logic              RdEn;
    logic [AW-1:0]     RdAddr;
    logic [WIDTH-1:0]  RdData;
    logic              RdValid;
    logic [NUM_CH-1:0] Ovf;

    modport master (
        output En, Event, Clr, CfgWe, CfgAddr, CfgDiv, RdEn, RdAddr,
        input  RdData, RdValid, Ovf
    );

    modport slave (
        input  En, Event, Clr, CfgWe, CfgAddr, CfgDiv, RdEn, RdAddr,
        output RdData, RdValid, Ovf
    );

endinterface

// File: rtl/perf_counter_channel.sv
// One counter channel: event prescaler, counter with wrap/saturate, sticky overflow.
module perf_counter_channel
    import perf_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int DIV_W    = 8,
    parameter int SATURATE = PERF_MODE_WRAP
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             en,
    input  logic             evt,
    input  logic             clr,
    input  logic             cfg_hit,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] count,
    output logic             ovf
);

    logic [DIV_W-1:0] pre_reg;
    logic [WIDTH-1:0] count_reg;
    logic             ovf_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            pre_reg   <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else if (clr) begin
            pre_reg   <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else if (cfg_hit) begin
            // New divisor restarts the prescaler; the coincident event is dropped.
            pre_reg <= '0;
        end else if (en && evt) begin
            if ((pre_reg + DIV_W'(1)) == div) begin
                pre_reg <= '0;
                if (&count_reg) begin
                    ovf_reg   <= 1'b1;
                    count_reg <= (SATURATE == PERF_MODE_SAT) ? count_reg : '0;
                end else begin
                    count_reg <= count_reg + WIDTH'(1);
                end
            end else begin
                pre_reg <= pre_reg + DIV_W'(1);
            end
        end
    end

    assign count = count_reg;
    assign ovf   = ovf_reg;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of event counters with per-channel divisors and a registered read port.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int WIDTH    = 64,
    parameter int DIV_W    = 8,
    parameter int SATURATE = PERF_MODE_WRAP
) (
    input  logic               Clk,
    input  logic               Reset,
    perf_counter_bank_if.slave bus
);

    localparam int AW = perf_addr_w(NUM_CH);

    logic [WIDTH-1:0]  count [NUM_CH];
    logic [NUM_CH-1:0] ovf;
    logic [NUM_CH-1:0] cfg_hit;
    logic [WIDTH-1:0]  rd_data_reg;
    logic              rd_valid_reg;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DIV_W-1:0] div_reg;
            logic [DIV_W-1:0] div_eff;

            // An out-of-range CfgAddr never matches any channel index.
            assign cfg_hit[gi] = bus.CfgWe && (bus.CfgAddr == AW'(gi));
            assign div_eff     = (div_reg == '0) ? DIV_W'(1) : div_reg;

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    div_reg <= DIV_W'(PERF_DEFAULT_DIV);
                end else if (cfg_hit[gi] && !bus.Clr[gi]) begin
                    div_reg <= bus.CfgDiv;
                end
            end

            perf_counter_channel #(
                .WIDTH    (WIDTH),
                .DIV_W    (DIV_W),
                .SATURATE (SATURATE)
            ) u_ch (
                .clk     (Clk),
                .srst    (Reset),
                .en      (bus.En),
                .evt     (bus.Event[gi]),
                .clr     (bus.Clr[gi]),
                .cfg_hit (cfg_hit[gi]),
                .div     (div_eff),
                .count   (count[gi]),
                .ovf     (ovf[gi])
            );
        end
    endgenerate

    // Samples the counters before this edge's update, so a read sees pre-clear values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= bus.RdEn;
            if (bus.RdEn) begin
                rd_data_reg <= (int'(bus.RdAddr) < NUM_CH) ? count[bus.RdAddr] : '0;
            end
        end
    end

    assign bus.RdData  = rd_data_reg;
    assign bus.RdValid = rd_valid_reg;
    assign bus.Ovf     = ovf;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench: a 64-bit wrap bank plus two 8-bit banks (wrap and saturate) driven in lockstep.
module tb_perf_counter_bank;

    typedef struct {
        logic [63:0] data;
        int          due;
    } exp_t;

    logic clk;
    logic rst_m;
    logic rst_s;
    int   cyc_cnt;
    int   vectors;
    int   fails;
    exp_t q [3][$];

    perf_counter_bank_if #(.NUM_CH(4), .WIDTH(64), .DIV_W(8)) m ();
    perf_counter_bank_if #(.NUM_CH(5), .WIDTH(8),  .DIV_W(8)) w ();
    perf_counter_bank_if #(.NUM_CH(5), .WIDTH(8),  .DIV_W(8)) s ();

    perf_counter_bank #(.NUM_CH(4), .WIDTH(64), .DIV_W(8), .SATURATE(0)) u_main (
        .Clk(clk), .Reset(rst_m), .bus(m));
    perf_counter_bank #(.NUM_CH(5), .WIDTH(8), .DIV_W(8), .SATURATE(0)) u_wrap8 (
        .Clk(clk), .Reset(rst_s), .bus(w));
    perf_counter_bank #(.NUM_CH(5), .WIDTH(8), .DIV_W(8), .SATURATE(1)) u_sat8 (
        .Clk(clk), .Reset(rst_s), .bus(s));

    // The saturating bank mirrors every input of the wrapping bank.
    assign s.En      = w.En;
    assign s.Event   = w.Event;
    assign s.Clr     = w.Clr;
    assign s.CfgWe   = w.CfgWe;
    assign s.CfgAddr = w.CfgAddr;
    assign s.CfgDiv  = w.CfgDiv;
    assign s.RdEn    = w.RdEn;
    assign s.RdAddr  = w.RdAddr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Monitor: every RdValid pops one expectation and must arrive in its due cycle.
    always @(negedge clk) begin
        logic        v [3];
        logic [63:0] d [3];
        string       nm;
        exp_t        e;
        v[0] = m.RdValid; d[0] = m.RdData;
        v[1] = w.RdValid; d[1] = 64'(w.RdData);
        v[2] = s.RdValid; d[2] = 64'(s.RdData);
        for (int i = 0; i < 3; i++) begin
            nm = (i == 0) ? "main" : (i == 1) ? "wrap8" : "sat8";
            if (v[i]) begin
                vectors++;
                if (q[i].size() == 0) begin
                    fails++;
                    $display("FAIL rd_%s: unexpected RdValid data=%0d at cycle %0d", nm, d[i], cyc_cnt);
                end else begin
                    e = q[i].pop_front();
                    if (d[i] !== e.data || cyc_cnt != e.due) begin
                        fails++;
                        $display("FAIL rd_%s: got data=%0d cycle=%0d, expected data=%0d cycle=%0d",
                                 nm, d[i], cyc_cnt, e.data, e.due);
                    end
                end
            end else if (q[i].size() != 0 && q[i][0].due <= cyc_cnt) begin
                vectors++;
                fails++;
                e = q[i].pop_front();
                $display("FAIL rd_%s: RdValid low in cycle %0d, expected data=%0d", nm, cyc_cnt, e.data);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic rd_m(input int addr, input logic [63:0] exp);
        exp_t e;
        e.data = exp;
        e.due  = cyc_cnt + 1;
        q[0].push_back(e);
        m.RdEn   = 1'b1;
        m.RdAddr = 2'(addr);
        cyc(1);
        m.RdEn = 1'b0;
        $display("read main ch%0d expect %0d", addr, exp);
    endtask

    task automatic rd_s(input int addr, input logic [63:0] exp_w, input logic [63:0] exp_s);
        exp_t e;
        e.due  = cyc_cnt + 1;
        e.data = exp_w;
        q[1].push_back(e);
        e.data = exp_s;
        q[2].push_back(e);
        w.RdEn   = 1'b1;
        w.RdAddr = 3'(addr);
        cyc(1);
        w.RdEn = 1'b0;
        $display("read small ch%0d expect wrap=%0d sat=%0d", addr, exp_w, exp_s);
    endtask

    task automatic cfg_m(input int addr, input int div);
        m.CfgWe   = 1'b1;
        m.CfgAddr = 2'(addr);
        m.CfgDiv  = 8'(div);
        cyc(1);
        m.CfgWe = 1'b0;
    endtask

    task automatic cfg_s(input int addr, input int div);
        w.CfgWe   = 1'b1;
        w.CfgAddr = 3'(addr);
        w.CfgDiv  = 8'(div);
        cyc(1);
        w.CfgWe = 1'b0;
    endtask

    initial begin
        cyc_cnt = 0;
        vectors = 0;
        fails   = 0;
        rst_m = 1'b1; rst_s = 1'b1;
        m.En = 1'b0; m.Event = '0; m.Clr = '0; m.CfgWe = 1'b0; m.CfgAddr = '0;
        m.CfgDiv = '0; m.RdEn = 1'b0; m.RdAddr = '0;
        w.En = 1'b0; w.Event = '0; w.Clr = '0; w.CfgWe = 1'b0; w.CfgAddr = '0;
        w.CfgDiv = '0; w.RdEn = 1'b0; w.RdAddr = '0;
        cyc(2);
        rst_m = 1'b0; rst_s = 1'b0;

        chk("main_rddata_reset", m.RdData, 64'd0);
        chk("main_ovf_reset", 64'(m.Ovf), 64'd0);
        rd_m(0, 0);

        // Divisor 1: every event counts.
        m.En = 1'b1;
        m.Event = 4'b0001; cyc(10); m.Event = '0;
        rd_m(0, 10);

        // Divisor 4 on ch1: steps on the 4th, 8th, 12th, 16th event.
        cfg_m(1, 4);
        m.Event = 4'b0010; cyc(13); m.Event = '0;
        rd_m(1, 3);
        m.Event = 4'b0010; cyc(2); m.Event = '0;
        rd_m(1, 3);
        m.Event = 4'b0010; cyc(1); m.Event = '0;
        rd_m(1, 4);

        // Divisor write drops a coincident event; divisor 0 behaves as 1.
        m.Event = 4'b0001; cfg_m(0, 0); m.Event = '0;
        rd_m(0, 10);
        m.Event = 4'b0001; cyc(2); m.Event = '0;
        rd_m(0, 12);

        // Clear with event: read in the same cycle returns pre-clear value.
        m.Event = 4'b0100; cyc(7); m.Event = '0;
        m.Clr = 4'b0100; m.Event = 4'b0100;
        rd_m(2, 7);
        m.Clr = '0; m.Event = '0;
        rd_m(2, 0);

        // En low for 5 of 20 event cycles with divisor 3.
        cfg_m(3, 3);
        m.Event = 4'b1000;
        for (int i = 0; i < 20; i++) begin
            m.En = !(i >= 5 && i < 10);
            cyc(1);
        end
        m.En = 1'b1; m.Event = '0;
        rd_m(3, 5);
        m.Event = 4'b1000; cyc(2); m.Event = '0;
        rd_m(3, 5);
        m.Event = 4'b1000; cyc(1); m.Event = '0;
        rd_m(3, 6);
        rd_m(1, 4);
        rd_m(0, 12);
        cyc(2);
        chk("main_rddata_hold", m.RdData, 64'd12);
        chk("main_ovf_none", 64'(m.Ovf), 64'd0);

        // 8-bit banks: out-of-range divisor write must touch no channel.
        cfg_s(7, 9);
        w.En = 1'b1;
        w.Event = 5'b01001; cyc(255); w.Event = '0;
        rd_s(0, 255, 255);
        rd_s(3, 255, 255);
        chk("wrap8_ovf_at_max", 64'(w.Ovf), 64'd0);
        chk("sat8_ovf_at_max", 64'(s.Ovf), 64'd0);
        w.Event = 5'b01001; cyc(2); w.Event = '0;
        rd_s(0, 1, 255);
        chk("wrap8_ovf_set", 64'(w.Ovf), 64'b01001);
        chk("sat8_ovf_set", 64'(s.Ovf), 64'b01001);
        w.Event = 5'b01000; cyc(8); w.Event = '0;
        rd_s(3, 9, 255);
        rd_s(6, 0, 0);

        // Clr drops the sticky flag of its own channel only.
        w.Clr = 5'b00001; cyc(1); w.Clr = '0;
        chk("wrap8_ovf_clr", 64'(w.Ovf), 64'b01000);
        chk("sat8_ovf_clr", 64'(s.Ovf), 64'b01000);

        // Reset mid-count restores counters, flags, divisors and read data.
        cfg_s(1, 5);
        rst_s = 1'b1; w.Event = 5'b11111; cyc(1);
        rst_s = 1'b0; w.Event = '0;
        chk("wrap8_ovf_reset", 64'(w.Ovf), 64'd0);
        chk("sat8_ovf_reset", 64'(s.Ovf), 64'd0);
        chk("wrap8_rddata_reset", 64'(w.RdData), 64'd0);
        chk("sat8_rddata_reset", 64'(s.RdData), 64'd0);
        rd_s(3, 0, 0);
        w.Event = 5'b00010; cyc(1); w.Event = '0;
        rd_s(1, 1, 1);

        cyc(4);
        for (int i = 0; i < 3; i++) begin
            if (q[i].size() != 0) begin
                vectors++;
                fails++;
                $display("FAIL rd_drain: scoreboard %0d has %0d pending reads, expected 0", i, q[i].size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
